// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings and default widths for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH   = 10;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_LEN_WIDTH    = 4;
    localparam int DEF_STARVE_LIMIT = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Which requester the read issued this cycle belongs to.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_PIPE = 2'd1,
        TAG_FRM  = 2'd2
    } rtag_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between memory stage, frame engine, DataMem and the arbiter
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
    logic                  I_PipeReq;
    logic                  I_PipeWe;
    logic [ADDR_WIDTH-1:0] I_PipeAddr;
    logic [DATA_WIDTH-1:0] I_PipeWData;
    logic                  O_PipeGnt;
    logic [DATA_WIDTH-1:0] O_PipeRData;
    logic                  O_PipeRValid;
    logic                  O_FrameStall;

    logic                  I_FrmReq;
    logic [ADDR_WIDTH-1:0] I_FrmAddr;
    logic [LEN_WIDTH-1:0]  I_FrmLen;
    logic                  O_FrmGnt;
    logic [DATA_WIDTH-1:0] O_FrmRData;
    logic                  O_FrmRValid;
    logic                  O_FrmDone;

    logic                  O_MemEn;
    logic                  O_MemWe;
    logic [ADDR_WIDTH-1:0] O_MemAddr;
    logic [DATA_WIDTH-1:0] O_MemWData;
    logic [DATA_WIDTH-1:0] I_MemRData;

    // Arbiter side.
    modport slave (
        input  I_PipeReq, I_PipeWe, I_PipeAddr, I_PipeWData,
        input  I_FrmReq, I_FrmAddr, I_FrmLen, I_MemRData,
        output O_PipeGnt, O_PipeRData, O_PipeRValid, O_FrameStall,
        output O_FrmGnt, O_FrmRData, O_FrmRValid, O_FrmDone,
        output O_MemEn, O_MemWe, O_MemAddr, O_MemWData
    );

    // Requesters and memory side.
    modport master (
        output I_PipeReq, I_PipeWe, I_PipeAddr, I_PipeWData,
        output I_FrmReq, I_FrmAddr, I_FrmLen, I_MemRData,
        input  O_PipeGnt, O_PipeRData, O_PipeRValid, O_FrameStall,
        input  O_FrmGnt, O_FrmRData, O_FrmRValid, O_FrmDone,
        input  O_MemEn, O_MemWe, O_MemAddr, O_MemWData
    );

endinterface

// File: rtl/dmem_arbiter_rtag.sv
// rtl/dmem_arbiter_rtag.sv - read-return tag register routing DataMem read data to its owner
module dmem_arbiter_rtag
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  rtag_e                 tag_d,
    input  logic                  last_d,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] pipe_rdata,
    output logic                  pipe_rvalid,
    output logic [DATA_WIDTH-1:0] frm_rdata,
    output logic                  frm_rvalid,
    output logic                  frm_done
);
    rtag_e tag_q;
    logic  last_q;

    // Remember who owns the read issued at this edge; its data appears on mem_rdata afterwards.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q  <= TAG_NONE;
            last_q <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            last_q <= last_d;
        end
    end

    // Register the returning word into the owner's output; data holds between valid pulses.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_rdata  <= '0;
            pipe_rvalid <= 1'b0;
            frm_rdata   <= '0;
            frm_rvalid  <= 1'b0;
            frm_done    <= 1'b0;
        end else begin
            pipe_rvalid <= (tag_q == TAG_PIPE);
            frm_rvalid  <= (tag_q == TAG_FRM);
            frm_done    <= (tag_q == TAG_FRM) && last_q;
            if (tag_q == TAG_PIPE) pipe_rdata <= mem_rdata;
            if (tag_q == TAG_FRM)  frm_rdata  <= mem_rdata;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares DataMem between the memory stage and the frame engine burst reader
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic     I_CLOCK,
    input  logic     I_RESET_N,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  left_q, left_d;
    logic [CNT_WIDTH-1:0]  starve_q, starve_d;

    logic                  frm_starved;
    logic                  pipe_gnt, frm_gnt;
    logic                  mem_en, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    rtag_e                 tag_d;
    logic                  last_d;

    // Arbitration state, burst address/beat counters and the frame starvation counter.
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q  <= ARB_IDLE;
            addr_q   <= '0;
            left_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            left_q   <= left_d;
            starve_q <= starve_d;
        end
    end

    // Pick the port owner, drive DataMem, and compute next state; all outputs stay low in reset.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        starve_d    = starve_q;
        pipe_gnt    = 1'b0;
        frm_gnt     = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        tag_d       = TAG_NONE;
        last_d      = 1'b0;
        frm_starved = bus.I_FrmReq && (starve_q == CNT_WIDTH'(STARVE_LIMIT));
        if (I_RESET_N) begin
            case (state_q)
                ARB_IDLE: begin
                    if (bus.I_PipeReq && !frm_starved) begin
                        pipe_gnt  = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = bus.I_PipeWe;
                        mem_addr  = bus.I_PipeAddr;
                        mem_wdata = bus.I_PipeWData;
                        tag_d     = bus.I_PipeWe ? TAG_NONE : TAG_PIPE;
                    end else if (bus.I_FrmReq) begin
                        // left counts beats still owed after this one; length 0 wraps to the maximum.
                        frm_gnt  = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = bus.I_FrmAddr;
                        tag_d    = TAG_FRM;
                        last_d   = (bus.I_FrmLen == LEN_WIDTH'(1));
                        addr_d   = bus.I_FrmAddr + ADDR_WIDTH'(1);
                        left_d   = bus.I_FrmLen - LEN_WIDTH'(1);
                        if (!last_d) state_d = ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                    tag_d    = TAG_FRM;
                    last_d   = (left_q == LEN_WIDTH'(1));
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    left_d   = left_q - LEN_WIDTH'(1);
                    if (last_d) state_d = ARB_IDLE;
                end
                default: state_d = ARB_IDLE;
            endcase
            if (bus.I_FrmReq && !frm_gnt)
                starve_d = (starve_q == CNT_WIDTH'(STARVE_LIMIT)) ? starve_q : starve_q + CNT_WIDTH'(1);
            else
                starve_d = '0;
        end
    end

    assign bus.O_PipeGnt    = pipe_gnt;
    assign bus.O_FrmGnt     = frm_gnt;
    assign bus.O_FrameStall = I_RESET_N && bus.I_PipeReq && !pipe_gnt;
    assign bus.O_MemEn      = mem_en;
    assign bus.O_MemWe      = mem_we;
    assign bus.O_MemAddr    = mem_addr;
    assign bus.O_MemWData   = mem_wdata;

    logic [DATA_WIDTH-1:0] pipe_rdata, frm_rdata;
    logic                  pipe_rvalid, frm_rvalid, frm_done;

    dmem_arbiter_rtag #(.DATA_WIDTH(DATA_WIDTH)) u_rtag (
        .clk         (I_CLOCK),
        .rst_n       (I_RESET_N),
        .tag_d       (tag_d),
        .last_d      (last_d),
        .mem_rdata   (bus.I_MemRData),
        .pipe_rdata  (pipe_rdata),
        .pipe_rvalid (pipe_rvalid),
        .frm_rdata   (frm_rdata),
        .frm_rvalid  (frm_rvalid),
        .frm_done    (frm_done)
    );

    assign bus.O_PipeRData  = pipe_rdata;
    assign bus.O_PipeRValid = pipe_rvalid;
    assign bus.O_FrmRData   = frm_rdata;
    assign bus.O_FrmRValid  = frm_rvalid;
    assign bus.O_FrmDone    = frm_done;

endmodule
